width_pack: RTL and testbench

WIDTH_PACK -- requirements
Module: width_pack

---
 rtl/width_pack.sv | 102 ++++++++++
 tb/tb_width_pack.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/width_pack.sv
// Packs IWIDTH-bit fragments into OWIDTH-bit words, LSB slot first.
// A fragment flagged din_last closes the word early and the unfilled slots read as zero.
module width_pack #(
  parameter int IWIDTH = 36,
  parameter int OWIDTH = 288
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [IWIDTH-1:0]                 din,
  input  logic                              din_valid,
  input  logic                              din_last,
  output logic                              din_ready,
  output logic [OWIDTH-1:0]                 dout,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [$clog2(OWIDTH/IWIDTH):0]    dout_cnt,
  output logic                              dout_last,
  output logic                              busy
);

  localparam int AMOUNT    = OWIDTH / IWIDTH;
  localparam int CNT_WIDTH = $clog2(AMOUNT);
  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(AMOUNT - 1);

  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [OWIDTH-1:0]    acc_reg;
  logic [OWIDTH-1:0]    acc_next;
  logic [OWIDTH-1:0]    word_next;
  logic [AMOUNT-1:0]    slot_hit;

  logic [OWIDTH-1:0]    dout_reg;
  logic [CNT_WIDTH:0]   dout_cnt_reg;
  logic                 dout_last_reg;
  logic                 dout_valid_reg;

  logic accept;
  logic pop;
  logic closing;
  logic complete;

  // A fragment that would close a word must wait while the output register is stalled.
  assign closing   = (cnt_r == LAST_SLOT) | din_last;
  assign din_ready = ~(dout_valid_reg & ~dout_ready & closing);
  assign accept    = din_valid & din_ready;
  assign pop       = dout_valid_reg & dout_ready;
  assign complete  = accept & closing;

  genvar gi;
  generate
    for (gi = 0; gi < AMOUNT; gi++) begin : g_slot
      assign slot_hit[gi] = accept & (cnt_r == CNT_WIDTH'(gi));
      assign word_next[gi*IWIDTH +: IWIDTH] =
        slot_hit[gi] ? din : acc_reg[gi*IWIDTH +: IWIDTH];
    end
  endgenerate

  // Slots above the fill point are always zero, so a short word needs no masking.
  assign acc_next = complete ? '0 : word_next;

  always_comb begin
    cnt_next = cnt_r;
    if (complete) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next = cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r   <= '0;
      acc_reg <= '0;
    end else begin
      cnt_r   <= cnt_next;
      acc_reg <= acc_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_reg       <= '0;
      dout_cnt_reg   <= '0;
      dout_last_reg  <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else if (complete) begin
      dout_reg       <= word_next;
      dout_cnt_reg   <= {1'b0, cnt_r} + 1'b1;
      dout_last_reg  <= din_last;
      dout_valid_reg <= 1'b1;
    end else if (pop) begin
      dout_valid_reg <= 1'b0;
    end
  end

  assign dout       = dout_reg;
  assign dout_cnt   = dout_cnt_reg;
  assign dout_last  = dout_last_reg;
  assign dout_valid = dout_valid_reg;
  assign busy       = (cnt_r != '0);

endmodule

// File: tb/tb_width_pack.sv
// Directed bench for width_pack at default widths (36-bit fragments, 8 per word).
module tb_width_pack;

  localparam int IW = 36;
  localparam int OW = 288;

  logic          clk = 1'b0;
  logic          resetn;
  logic [IW-1:0] din;
  logic          din_valid;
  logic          din_last;
  logic          din_ready;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [3:0]    dout_cnt;
  logic          dout_last;
  logic          busy;

  int tests = 0;
  int fails = 0;

  width_pack #(.IWIDTH(IW), .OWIDTH(OW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_cnt   (dout_cnt),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word whose slot k holds base+k for k < n, zero above.
  function automatic logic [OW-1:0] mk(input logic [IW-1:0] base, input int n);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*IW +: IW] = base + IW'(k);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [IW-1:0] d, input logic l);
    din       = d;
    din_last  = l;
    din_valid = 1'b1;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din_last  = 1'b0;
    din       = '0;
  endtask

  initial begin
    resetn     = 1'b0;
    dout_ready = 1'b1;
    idle();
    #12;
    $display("[TB] reset state");
    check("rst_dout_valid", OW'(dout_valid), OW'(0));
    check("rst_din_ready",  OW'(din_ready),  OW'(1));
    check("rst_busy",       OW'(busy),       OW'(0));
    check("rst_dout",       dout,            '0);
    check("rst_dout_cnt",   OW'(dout_cnt),   OW'(0));
    resetn = 1'b1;
    step();

    // Back-to-back full word 0x1..0x8
    for (int i = 0; i < 8; i++) begin
      present(IW'(i + 1), 1'b0);
      check("b2b_din_ready", OW'(din_ready), OW'(1));
      step();
      if (i < 7) check("b2b_no_valid_yet", OW'(dout_valid), OW'(0));
    end
    idle();
    $display("[TB] b2b word dout=%0h cnt=%0d", dout, dout_cnt);
    check("b2b_valid", OW'(dout_valid), OW'(1));
    check("b2b_dout",  dout,            mk(36'h1, 8));
    check("b2b_cnt",   OW'(dout_cnt),   OW'(8));
    check("b2b_last",  OW'(dout_last),  OW'(0));
    check("b2b_busy",  OW'(busy),       OW'(0));
    step();
    check("b2b_popped", OW'(dout_valid), OW'(0));

    // Early close on third fragment
    present(36'hA, 1'b0); step();
    present(36'hB, 1'b0); step();
    present(36'hC, 1'b1); step();
    idle();
    $display("[TB] short word dout=%0h cnt=%0d last=%0d", dout, dout_cnt, dout_last);
    check("short_valid", OW'(dout_valid), OW'(1));
    check("short_dout",  dout,            mk(36'hA, 3));
    check("short_cnt",   OW'(dout_cnt),   OW'(3));
    check("short_last",  OW'(dout_last),  OW'(1));
    step();
    present(36'hD, 1'b1); step();
    idle();
    $display("[TB] single-slot word dout=%0h cnt=%0d", dout, dout_cnt);
    check("slot0_dout", dout,          mk(36'hD, 1));
    check("slot0_cnt",  OW'(dout_cnt), OW'(1));
    step();

    // Backpressure: word 1 stalls while word 2 fills behind it
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      present(36'h11 + IW'(i), 1'b0); step();
    end
    for (int i = 0; i < 7; i++) begin
      present(36'h21 + IW'(i), 1'b0);
      check("bp_accept_partial", OW'(din_ready), OW'(1));
      step();
    end
    present(36'h28, 1'b0);
    check("bp_ready_low", OW'(din_ready), OW'(0));
    step();
    $display("[TB] stalled dout=%0h busy=%0d", dout, busy);
    check("bp_hold_dout",  dout,            mk(36'h11, 8));
    check("bp_hold_valid", OW'(dout_valid), OW'(1));
    check("bp_busy",       OW'(busy),       OW'(1));
    dout_ready = 1'b1;
    #1;
    check("bp_ready_back", OW'(din_ready), OW'(1));
    step();
    idle();
    $display("[TB] released dout=%0h cnt=%0d", dout, dout_cnt);
    check("bp_word2_valid", OW'(dout_valid), OW'(1));
    check("bp_word2_dout",  dout,            mk(36'h21, 8));
    check("bp_word2_cnt",   OW'(dout_cnt),   OW'(8));
    step();
    check("bp_drained", OW'(dout_valid), OW'(0));

    // Streaming 32 fragments
    for (int i = 0; i < 32; i++) begin
      present(36'h100 + IW'(i), 1'b0);
      check("stream_ready", OW'(din_ready), OW'(1));
      step();
      if (i % 8 == 7) begin
        $display("[TB] stream word %0d dout=%0h", i / 8, dout);
        check("stream_valid", OW'(dout_valid), OW'(1));
        check("stream_dout",  dout, mk(36'h100 + IW'(i - 7), 8));
      end else begin
        check("stream_gap", OW'(dout_valid), OW'(0));
      end
    end
    idle();
    step();

    // Reset with a half-filled word
    for (int i = 0; i < 4; i++) begin
      present(36'h31 + IW'(i), 1'b0); step();
    end
    idle();
    check("pre_rst_busy", OW'(busy), OW'(1));
    #2 resetn = 1'b0;
    #1;
    $display("[TB] mid-word reset busy=%0d ready=%0d", busy, din_ready);
    check("mrst_valid", OW'(dout_valid), OW'(0));
    check("mrst_busy",  OW'(busy),       OW'(0));
    check("mrst_ready", OW'(din_ready),  OW'(1));
    #4 resetn = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      present(36'h41 + IW'(i), 1'b0); step();
    end
    idle();
    $display("[TB] post-reset word dout=%0h cnt=%0d", dout, dout_cnt);
    check("mrst_word", dout,          mk(36'h41, 8));
    check("mrst_cnt",  OW'(dout_cnt), OW'(8));
    step();

    // Pop and completion on the same edge, no bubble
    present(36'h51, 1'b1); step();
    check("nb_first", dout, mk(36'h51, 1));
    present(36'h52, 1'b1);
    check("nb_ready", OW'(din_ready), OW'(1));
    step();
    $display("[TB] no-bubble dout=%0h valid=%0d", dout, dout_valid);
    check("nb_valid2", OW'(dout_valid), OW'(1));
    check("nb_second", dout,            mk(36'h52, 1));
    present(36'h53, 1'b1); step();
    idle();
    check("nb_valid3", OW'(dout_valid), OW'(1));
    check("nb_third",  dout,            mk(36'h53, 1));
    step();
    check("nb_drained", OW'(dout_valid), OW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
